// File: rtl/reorder_buffer.sv
// reorder_buffer: circular reorder buffer with in-order retire, CDB capture and branch-mispredict flush.
// Optional build: define ROB_COMMIT_TRACE_EN to add a cycle counter and a per-commit trace line.
module reorder_buffer #(
  parameter int RoB_WIDTH = 3,
  parameter int ROB_SIZE  = 1 << RoB_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_en,
  input  logic [1:0]           issue_type,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_pred_jump,
  output logic [RoB_WIDTH-1:0] tail_index,
  output logic                 rob_full,
  input  logic                 cdb_en,
  input  logic [RoB_WIDTH-1:0] cdb_index,
  input  logic [31:0]          cdb_data,
  input  logic                 cdb_jump,
  input  logic [31:0]          cdb_target,
  input  logic [RoB_WIDTH-1:0] query_j_idx,
  input  logic [RoB_WIDTH-1:0] query_k_idx,
  output logic                 query_j_ready,
  output logic                 query_k_ready,
  output logic [31:0]          query_j_data,
  output logic [31:0]          query_k_data,
  output logic                 RoB_update_en,
  output logic [4:0]           RoB_update_reg,
  output logic [RoB_WIDTH-1:0] RoB_update_index,
  output logic [31:0]          RoB_update_data,
  output logic                 store_commit_en,
  output logic [RoB_WIDTH-1:0] store_commit_index,
  output logic                 flush_signal,
  output logic [31:0]          redirect_pc,
  output logic                 halt
);
  localparam logic [1:0] TYPE_REG    = 2'd0;
  localparam logic [1:0] TYPE_BRANCH = 2'd1;
  localparam logic [1:0] TYPE_STORE  = 2'd2;
  localparam logic [1:0] TYPE_EXIT   = 2'd3;

  logic [RoB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [RoB_WIDTH:0]   count_q, count_d;
  logic [ROB_SIZE-1:0]  busy_q, busy_d, ready_q, ready_d, pred_q, pred_d, jump_q, jump_d;
  logic [1:0]           type_q [ROB_SIZE];
  logic [1:0]           type_d [ROB_SIZE];
  logic [4:0]           rd_q [ROB_SIZE];
  logic [4:0]           rd_d [ROB_SIZE];
  logic [31:0]          data_q [ROB_SIZE];
  logic [31:0]          data_d [ROB_SIZE];
  logic [31:0]          target_q [ROB_SIZE];
  logic [31:0]          target_d [ROB_SIZE];

  logic                 upd_en_q, upd_en_d, st_en_q, st_en_d, flush_q, flush_d, halt_q, halt_d;
  logic [4:0]           upd_reg_q, upd_reg_d;
  logic [RoB_WIDTH-1:0] upd_idx_q, upd_idx_d, st_idx_q, st_idx_d;
  logic [31:0]          upd_data_q, upd_data_d, redirect_q, redirect_d;

  logic full_s, issue_acc_s, cdb_acc_s, commit_s, mispredict_s, hit_j_s, hit_k_s;

  // Commit looks only at stored ready bits, so a same-edge CDB write retires one edge later.
  assign full_s       = (count_q == (RoB_WIDTH+1)'(ROB_SIZE));
  assign issue_acc_s  = rdy_in && issue_en && !full_s && !flush_q;
  assign cdb_acc_s    = rdy_in && cdb_en && !flush_q && busy_q[cdb_index];
  assign commit_s     = rdy_in && !flush_q && !halt_q && busy_q[head_q] && ready_q[head_q];
  assign mispredict_s = commit_s && (type_q[head_q] == TYPE_BRANCH) &&
                        (jump_q[head_q] != pred_q[head_q]);

  // Entry array and pointer next state.
  always_comb begin
    for (int i = 0; i < ROB_SIZE; i++) begin
      if (mispredict_s) begin
        busy_d[i] = 1'b0;
      end else if (commit_s && (head_q == RoB_WIDTH'(i))) begin
        busy_d[i] = 1'b0;
      end else if (issue_acc_s && (tail_q == RoB_WIDTH'(i))) begin
        busy_d[i] = 1'b1;
      end else begin
        busy_d[i] = busy_q[i];
      end
      if (issue_acc_s && (tail_q == RoB_WIDTH'(i))) begin
        ready_d[i] = 1'b0;
        type_d[i]  = issue_type;
        rd_d[i]    = issue_rd;
        pred_d[i]  = issue_pred_jump;
      end else begin
        ready_d[i] = (cdb_acc_s && (cdb_index == RoB_WIDTH'(i))) ? 1'b1 : ready_q[i];
        type_d[i]  = type_q[i];
        rd_d[i]    = rd_q[i];
        pred_d[i]  = pred_q[i];
      end
      if (cdb_acc_s && (cdb_index == RoB_WIDTH'(i))) begin
        data_d[i]   = cdb_data;
        jump_d[i]   = cdb_jump;
        target_d[i] = cdb_target;
      end else begin
        data_d[i]   = data_q[i];
        jump_d[i]   = jump_q[i];
        target_d[i] = target_q[i];
      end
    end
    if (mispredict_s) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = commit_s ? head_q + RoB_WIDTH'(1) : head_q;
      tail_d  = issue_acc_s ? tail_q + RoB_WIDTH'(1) : tail_q;
      count_d = count_q + {{RoB_WIDTH{1'b0}}, issue_acc_s} - {{RoB_WIDTH{1'b0}}, commit_s};
    end
  end

  // Retire-side output next state; everything holds while stalled.
  always_comb begin
    upd_en_d   = upd_en_q;
    upd_reg_d  = upd_reg_q;
    upd_idx_d  = upd_idx_q;
    upd_data_d = upd_data_q;
    st_en_d    = st_en_q;
    st_idx_d   = st_idx_q;
    flush_d    = flush_q;
    redirect_d = redirect_q;
    halt_d     = halt_q;
    if (!rdy_in) begin
      halt_d = halt_q;
    end else if (commit_s) begin
      upd_en_d = 1'b0;
      st_en_d  = 1'b0;
      flush_d  = 1'b0;
      case (type_q[head_q])
        TYPE_REG, TYPE_BRANCH: begin
          upd_en_d   = 1'b1;
          upd_reg_d  = rd_q[head_q];
          upd_idx_d  = head_q;
          upd_data_d = data_q[head_q];
          if (mispredict_s) begin
            flush_d    = 1'b1;
            redirect_d = target_q[head_q];
          end else begin
            flush_d    = 1'b0;
          end
        end
        TYPE_STORE: begin
          st_en_d  = 1'b1;
          st_idx_d = head_q;
        end
        TYPE_EXIT: halt_d = 1'b1;
        default:   halt_d = halt_q;
      endcase
    end else begin
      upd_en_d = 1'b0;
      st_en_d  = 1'b0;
      flush_d  = 1'b0;
    end
  end

  // Operand lookup with same-cycle CDB forwarding.
  always_comb begin
    hit_j_s = cdb_en && (cdb_index == query_j_idx);
    hit_k_s = cdb_en && (cdb_index == query_k_idx);
    if (busy_q[query_j_idx] && (ready_q[query_j_idx] || hit_j_s)) begin
      query_j_ready = 1'b1;
      query_j_data  = hit_j_s ? cdb_data : data_q[query_j_idx];
    end else begin
      query_j_ready = 1'b0;
      query_j_data  = 32'd0;
    end
    if (busy_q[query_k_idx] && (ready_q[query_k_idx] || hit_k_s)) begin
      query_k_ready = 1'b1;
      query_k_data  = hit_k_s ? cdb_data : data_q[query_k_idx];
    end else begin
      query_k_ready = 1'b0;
      query_k_data  = 32'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      busy_q     <= '0;
      ready_q    <= '0;
      pred_q     <= '0;
      jump_q     <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        type_q[i]   <= 2'd0;
        rd_q[i]     <= 5'd0;
        data_q[i]   <= 32'd0;
        target_q[i] <= 32'd0;
      end
      upd_en_q   <= 1'b0;
      upd_reg_q  <= 5'd0;
      upd_idx_q  <= '0;
      upd_data_q <= 32'd0;
      st_en_q    <= 1'b0;
      st_idx_q   <= '0;
      flush_q    <= 1'b0;
      redirect_q <= 32'd0;
      halt_q     <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      pred_q     <= pred_d;
      jump_q     <= jump_d;
      type_q     <= type_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      target_q   <= target_d;
      upd_en_q   <= upd_en_d;
      upd_reg_q  <= upd_reg_d;
      upd_idx_q  <= upd_idx_d;
      upd_data_q <= upd_data_d;
      st_en_q    <= st_en_d;
      st_idx_q   <= st_idx_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      halt_q     <= halt_d;
    end
  end

  assign tail_index         = tail_q;
  assign rob_full           = full_s;
  assign RoB_update_en      = upd_en_q;
  assign RoB_update_reg     = upd_reg_q;
  assign RoB_update_index   = upd_idx_q;
  assign RoB_update_data    = upd_data_q;
  assign store_commit_en    = st_en_q;
  assign store_commit_index = st_idx_q;
  assign flush_signal       = flush_q;
  assign redirect_pc        = redirect_q;
  assign halt               = halt_q;

`ifdef ROB_COMMIT_TRACE_EN
  logic [31:0] cycle_q, cycle_d;

  always_comb begin
    cycle_d = cycle_q + 32'd1;
  end

  // Free-running cycle counter for the trace.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_q <= 32'd0;
    end else begin
      cycle_q <= cycle_d;
    end
  end

  // One trace line per retired entry.
  always_ff @(posedge clk_in) begin
    if (rst_in && commit_s) begin
      if (mispredict_s) begin
        $display("[rob %0d] commit idx=%0d type=%0d rd=%0d data=%08h MISPREDICT target=%08h",
                 cycle_q, head_q, type_q[head_q], rd_q[head_q], data_q[head_q], target_q[head_q]);
      end else begin
        $display("[rob %0d] commit idx=%0d type=%0d rd=%0d data=%08h",
                 cycle_q, head_q, type_q[head_q], rd_q[head_q], data_q[head_q]);
      end
    end
  end
`endif
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer that sits between Dispatcher/CDB and the register file (RF).
- Allocates one entry per dispatched instruction and collects results from the CDB.
- Retires in program order, at most one per cycle, driving RoB_update_* (RF write-back) and flush_signal.
- On a mispredicted branch it flushes all speculative state and redirects fetch.

Parameters:
- RoB_WIDTH, 3, log2 of entry count; entry index width.
- ROB_SIZE, 1 << RoB_WIDTH, number of entries.

Ports:
- clk_in  in  1  clock; all state updates on posedge.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global stall; when 0 all state holds and registered outputs hold.
- issue_en  in  1  dispatch request; accepted only if !rob_full && !flush_signal.
- issue_type  in  2  0=REG, 1=BRANCH, 2=STORE, 3=EXIT.
- issue_rd  in  5  destination register; 0 = no write.
- issue_pred_jump  in  1  predicted direction (BRANCH only).
- tail_index  out  RoB_WIDTH  index the next accepted issue receives (new_entry_robEntry for RF).
- rob_full  out  1  count == ROB_SIZE.
- cdb_en  in  1  result broadcast valid.
- cdb_index  in  RoB_WIDTH  entry being completed.
- cdb_data  in  32  result value.
- cdb_jump  in  1  actual branch outcome.
- cdb_target  in  32  correct next PC for a BRANCH.
- query_j_idx, query_k_idx  in  RoB_WIDTH  operand lookups from Dispatcher.
- query_j_ready, query_k_ready  out  1  entry done, or being completed by the CDB this cycle.
- query_j_data, query_k_data  out  32  value; 0 when not ready.
- RoB_update_en  out  1  registered commit pulse to RF.
- RoB_update_reg  out  5  committed rd.
- RoB_update_index  out  RoB_WIDTH  committed entry index.
- RoB_update_data  out  32  committed value.
- store_commit_en  out  1  registered pulse: head STORE retired.
- store_commit_index  out  RoB_WIDTH  entry index of that store.
- flush_signal  out  1  registered one-cycle flush pulse.
- redirect_pc  out  32  correct PC, valid while flush_signal=1.
- halt  out  1  sticky; set when EXIT commits.

Behaviour:
- Reset (async, rst_in=0): head=tail=count=0; all busy/ready bits cleared; every output listed above =0; rob_full=0; tail_index=0.
- Per-entry state: busy, ready, type, rd, pred_jump, data[31:0], jump, target[31:0].
- Issue (posedge, rdy_in=1, issue_en && !rob_full && !flush_signal):
  - write entry[tail] with busy=1, ready=0 and the issue fields.
  - tail advances mod ROB_SIZE, wrapping 7->0 at the default size.
  - issue while full or during flush is dropped silently; no state change.
- CDB (posedge): if cdb_en && busy[cdb_index], set ready, data, jump, target. CDB to a non-busy entry is ignored.
- Commit (posedge): when busy[head] && ready[head] and !flush_signal:
  - REG: RoB_update_en=1 next cycle with rd, index=head, data. rd=0 still pulses, and RF ignores it.
  - BRANCH, correct prediction (jump==pred_jump): commit like REG so jal/jalr links are written.
  - BRANCH, mispredicted: RF update as for REG, plus next-cycle flush_signal=1 and redirect_pc=target. Same edge clears every busy bit; head=tail=count=0.
  - STORE: store_commit_en=1 with index=head; no RF update.
  - EXIT: halt=1; no further commits.
  - In every case busy[head]=0 and head advances.
- Pulse outputs (RoB_update_en, store_commit_en, flush_signal) are high for exactly one cycle per event and 0 otherwise.
- Commit latency: a CDB write at edge N makes the entry ready; commit happens at edge N+1; RoB_update_en is visible after edge N+1.
- Simultaneous issue + commit: count unchanged. A full buffer with a commit this edge still rejects issue (rob_full is registered-state based).
- Simultaneous CDB + commit on the same entry: the commit uses stored state only, so the entry commits one edge later.
- Query: combinational.
  - ready = ready[idx] || (cdb_en && cdb_index==idx); CDB value wins when both apply.
  - An index that is not busy returns ready=0.
- While flush_signal=1: issue, CDB and commit are all ignored; the buffer is empty.
- rdy_in=0: nothing changes; pulse outputs hold their current value.

Optional Feature:
- Macro: ROB_COMMIT_TRACE_EN.
- Defined: on every commit, $display prints cycle count, head index, type, rd, data, and "MISPREDICT target" for a flushing branch. A 32-bit cycle counter exists only in this build.
- Undefined: no counter and no display statements; functional behaviour is identical.

Test Plan:
- Reset, then issue REG rd=5 and CDB index0 data=0x1234 -> RoB_update_en pulses one cycle with reg=5, index=0, data=0x1234; count returns 0.
- Issue 8 REGs, then a 9th -> rob_full=1, 9th dropped, tail_index=0 after wrap. Complete entry0 -> commits; the next issue gets index0.
- Complete entries out of order (2,1,0) -> commits appear in order 0,1,2 on consecutive cycles.
- BRANCH pred_jump=0, CDB jump=1 target=0x100, younger REGs pending -> flush_signal one cycle with redirect_pc=0x100; head=tail=0; younger entries never commit.
- Query idx3 while cdb_en && cdb_index=3, data=0xABCD -> query ready=1, data=0xABCD in the same cycle. Query a non-busy idx -> ready=0, data=0.
- STORE then EXIT completed -> store_commit_en with index0, then halt=1; later completions produce no commits. Assert rst_in low mid-run -> all outputs 0 immediately, without a clock edge.
